// File: rtl/hwpe_stream_word_packer_if.sv
// HWPE stream bundle: valid/ready handshake carrying a data word and its byte strobes.
// source/sink are the HWPE names; master/slave are aliases with the same directions.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, output data, output strb, input  ready);
   modport sink   (input  valid, input  data, input  strb, output ready);
   modport master (output valid, output data, output strb, input  ready);
   modport slave  (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_word_packer.sv
// Packs NB_IN_WORDS narrow HWPE stream beats into one wide word, with flush of partial words.
// Output fields come straight from registers; a pop and the next word's first push may share a cycle.
module hwpe_stream_word_packer #(
   parameter int unsigned DATA_WIDTH_OUT = 128,
   parameter int unsigned NB_IN_WORDS    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   flush_i,
   hwpe_stream_intf_stream.sink   push_i,
   hwpe_stream_intf_stream.source pop_o
);
   localparam int unsigned DATA_WIDTH_IN  = DATA_WIDTH_OUT / NB_IN_WORDS;
   localparam int unsigned STRB_WIDTH_IN  = DATA_WIDTH_IN / 8;
   localparam int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / 8;
   localparam int unsigned CNT_W          = $clog2(NB_IN_WORDS);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NB_IN_WORDS - 1);

   logic [CNT_W-1:0]          count_reg, count_next;
   logic                      out_valid_reg, out_valid_next;
   logic [DATA_WIDTH_OUT-1:0] data_reg, data_next, data_base, data_lanes;
   logic [STRB_WIDTH_OUT-1:0] strb_reg, strb_next, strb_base, strb_lanes;
   logic [NB_IN_WORDS-1:0]    lane_sel;
   logic                      push_hs, pop_hs, push_ready;

   assign push_ready   = !out_valid_reg || pop_o.ready;
   assign push_i.ready = push_ready;
   assign push_hs      = push_i.valid && push_ready;
   assign pop_hs       = out_valid_reg && pop_o.ready;

   assign pop_o.valid  = out_valid_reg;
   assign pop_o.data   = data_reg;
   assign pop_o.strb   = strb_reg;

   // A popped word leaves a zeroed buffer so the next word never carries stale lanes.
   assign data_base = pop_hs ? '0 : data_reg;
   assign strb_base = pop_hs ? '0 : strb_reg;

   for (genvar gi = 0; gi < NB_IN_WORDS; gi++) begin : gen_lane
      assign lane_sel[gi] = push_hs && (count_reg == CNT_W'(gi));
      assign data_lanes[gi*DATA_WIDTH_IN +: DATA_WIDTH_IN] =
         lane_sel[gi] ? push_i.data : data_base[gi*DATA_WIDTH_IN +: DATA_WIDTH_IN];
      assign strb_lanes[gi*STRB_WIDTH_IN +: STRB_WIDTH_IN] =
         lane_sel[gi] ? push_i.strb : strb_base[gi*STRB_WIDTH_IN +: STRB_WIDTH_IN];
   end

   always_comb begin
      count_next     = count_reg;
      out_valid_next = out_valid_reg;
      data_next      = data_lanes;
      strb_next      = strb_lanes;
      if (pop_hs) begin
         out_valid_next = 1'b0;
      end
      if (push_hs) begin
         if (count_reg == LAST_IDX) begin
            count_next     = '0;
            out_valid_next = 1'b1;
         end else begin
            count_next = count_reg + CNT_W'(1);
         end
      end
      // Flush looks at the state after this cycle's push, so a flush on the last beat is a plain close.
      if (flush_i && (count_next != '0) && !out_valid_next) begin
         out_valid_next = 1'b1;
         count_next     = '0;
      end
      if (clear_i) begin
         count_next     = '0;
         out_valid_next = 1'b0;
         data_next      = '0;
         strb_next      = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         data_reg      <= '0;
         strb_reg      <= '0;
      end else begin
         count_reg     <= count_next;
         out_valid_reg <= out_valid_next;
         data_reg      <= data_next;
         strb_reg      <= strb_next;
      end
   end
endmodule

// File: doc/hwpe_stream_word_packer.md
Name: hwpe_stream_word_packer

Overview:
- Upstream neighbour of the stream splitter: packs NB_IN_WORDS consecutive narrow beats from one HWPE stream into a single wide word.
- Emits the wide word on a wide HWPE stream that feeds the splitter's push port.
- Sustains one narrow beat per cycle under no backpressure.
- Supports an explicit flush of a partially filled word; unfilled lanes are strobe-masked.

Parameters:
- DATA_WIDTH_OUT, 128, width of the packed output word. Must be a multiple of 8*NB_IN_WORDS.
- NB_IN_WORDS, 8, number of narrow beats per wide word. Power of two, at least 2.
- DATA_WIDTH_IN, DATA_WIDTH_OUT/NB_IN_WORDS, narrow beat width. Derived; do not override.
- STRB_WIDTH_IN / STRB_WIDTH_OUT, DATA_WIDTH_IN/8 / DATA_WIDTH_OUT/8, derived strobe widths.

Ports:
- clk_i  input  1  single clock; all state on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- clear_i  input  1  synchronous clear; drops any partial or pending word.
- flush_i  input  1  single-cycle pulse; closes the current partial word.
- push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH_IN  narrow input stream (valid, ready, data, strb).
- pop_o  hwpe_stream_intf_stream.source  DATA_WIDTH_OUT  wide output stream (valid, ready, data, strb).

Behaviour:
- State:
  - count register, 0..NB_IN_WORDS-1.
  - data buffer, DATA_WIDTH_OUT bits.
  - strobe buffer, STRB_WIDTH_OUT bits.
  - out_valid flag.
- Reset (rst_ni low, asynchronous):
  - count=0, out_valid=0, buffers=0.
  - pop_o.valid=0, pop_o.data=0, pop_o.strb=0.
  - push_i.ready=1 from the first cycle after reset release.
- Outputs:
  - pop_o.valid=out_valid; pop_o.data/strb driven directly from the buffers (registered, no combinational path from push_i).
  - push_i.ready = !out_valid || pop_o.ready.
- Push handshake (push_i.valid && push_i.ready), beat at count k:
  - data written to slice [k*DATA_WIDTH_IN +: DATA_WIDTH_IN]; strb written to slice [k*STRB_WIDTH_IN +: STRB_WIDTH_IN].
  - If k==NB_IN_WORDS-1: count wraps to 0 and out_valid=1 next cycle. Otherwise count=k+1.
- Latency: wide word is valid one cycle after the handshake of its last narrow beat.
- Pop handshake (pop_o.valid && pop_o.ready):
  - out_valid cleared and all buffer lanes zeroed, unless a new word is closed in the same cycle.
  - A push in the same cycle writes lane 0 of the fresh buffer: slice 0 holds the new beat, all other lanes and strobes are 0, count=1.
  - This gives full throughput with no bubble.
- Backpressure: while out_valid && !pop_o.ready:
  - push_i.ready=0.
  - buffers, count and pop_o fields held stable. HWPE rule: valid never deasserts without a handshake.
- Flush (flush_i=1), evaluated after any same-cycle push:
  - If the resulting count>0 and the word is not already closed: out_valid=1 and count=0. Unwritten lanes keep data 0 and strb 0.
  - If count==0: ignored.
  - If out_valid is already 1 and not popping: ignored.
  - A flush in the same cycle as a last-beat push is equivalent to a normal full close.
- clear_i (synchronous): count=0, out_valid=0, buffers=0 next cycle. Has priority over push, pop and flush in the same cycle; a beat handshaked in that cycle is discarded.
- Reset mid-operation: asynchronous. pop_o.valid drops immediately even if a word was pending; the partial word is lost.
- Input strb is passed through per lane; the block does not interpret it.

Test Plan (defaults: 16-bit narrow beats, 128-bit wide words):
- Reset:
  - Stimulus: assert rst_ni=0 mid-run with pop_o.valid=1.
  - Required: pop_o.valid=0, data=0, strb=0 asynchronously; push_i.ready=1 after release.
- Streaming:
  - Stimulus: push 16 beats 0x0001..0x0010 back-to-back with pop_o.ready=1.
  - Required: push_i.ready stays 1. Word 0x0008_0007_0006_0005_0004_0003_0002_0001 with strb 0xFFFF appears one cycle after beat 8. Word 0x0010_..._0009 appears exactly 8 cycles later.
- Backpressure:
  - Stimulus: hold pop_o.ready=0 after a full word, with push_i.valid=1 holding beat 0x00AA.
  - Required: push_i.ready=0 and pop_o stable for 5 cycles. On release, pop handshake and 0x00AA accepted in the same cycle; 0x00AA lands in lane 0 with count=1.
- Flush:
  - Stimulus: push 0x1111, 0x2222, 0x3333, then pulse flush_i.
  - Required: next cycle pop_o.data=0x...0000_3333_2222_1111 with upper 80 bits 0, strb=0x003F.
  - Stimulus: pulse flush_i again at count 0.
  - Required: no output.
- Clear:
  - Stimulus: push 5 beats, then clear_i=1 together with a 6th push.
  - Required: no word emitted. The next 8 beats form a clean word with strb 0xFFFF and no stale lanes.
- Simultaneous flush and last beat:
  - Stimulus: flush_i asserted on the 8th beat handshake.
  - Required: exactly one full word, strb 0xFFFF, no extra empty word.
